// File: rtl/dsc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsc_pkg
// Brief    : Shared types and constants for the DSC slice scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dsc_pkg;

    localparam int DSC_DIM_W = 16;
    localparam int DSC_TMO_W = 20;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [DSC_DIM_W-1:0] pic_w;
        logic [DSC_DIM_W-1:0] pic_h;
        logic [DSC_DIM_W-1:0] slice_w;
        logic [DSC_DIM_W-1:0] slice_h;
    } dsc_cfg_t;

endpackage
`default_nettype wire

// File: rtl/dsc_slice_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : dsc_slice_sched_if
// Brief    : Slice-command handshake between the scheduler and the DSC core.
// Revision : 1.0 - initial release
// ============================================================================
interface dsc_slice_sched_if import dsc_pkg::*; #(
    parameter int DIM_W = DSC_DIM_W
) ();
    logic             slc_vld;
    logic             slc_rdy;
    logic [DIM_W-1:0] slc_x;
    logic [DIM_W-1:0] slc_y;
    logic [DIM_W-1:0] slc_w;
    logic [DIM_W-1:0] slc_h;
    logic             slc_last;
    logic             slc_done;

    modport master (
        output slc_vld, slc_x, slc_y, slc_w, slc_h, slc_last,
        input  slc_rdy, slc_done
    );

    modport slave (
        input  slc_vld, slc_x, slc_y, slc_w, slc_h, slc_last,
        output slc_rdy, slc_done
    );
endinterface
`default_nettype wire

// File: rtl/dsc_slice_wdog.sv
`default_nettype none
// ============================================================================
// Module   : dsc_slice_wdog
// Brief    : Completion watchdog; flags a slice that stays outstanding too long.
// Revision : 1.0 - initial release
// ============================================================================
module dsc_slice_wdog import dsc_pkg::*; #(
    parameter int TMO_W = DSC_TMO_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic             i_run,
    input  wire logic [TMO_W-1:0] i_limit,
    output logic                  o_hit
);
    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    // Counter starts at 0 in the first waiting cycle, so limit-1 marks the limit-th cycle.
    assign o_hit = i_run && (i_limit != '0) && (r_cnt == (i_limit - TMO_W'(1)));
endmodule
`default_nettype wire

// File: rtl/dsc_slice_sched.sv
`default_nettype none
// ============================================================================
// Module   : dsc_slice_sched
// Brief    : Walks a picture in raster order issuing one slice command at a time.
//            Optional completion watchdog enabled by DSC_SLICE_TMO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dsc_slice_sched import dsc_pkg::*; #(
    parameter int DIM_W = DSC_DIM_W,
    parameter int TMO_W = DSC_TMO_W
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    input  wire logic [DIM_W-1:0]   pic_w,
    input  wire logic [DIM_W-1:0]   pic_h,
    input  wire logic [DIM_W-1:0]   slice_w,
    input  wire logic [DIM_W-1:0]   slice_h,
    dsc_slice_sched_if.master       slc,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    cfg_err,
    output logic [2*DIM_W-1:0]      slc_cnt
`ifdef DSC_SLICE_TMO_EN
    ,
    input  wire logic [TMO_W-1:0]   tmo_limit,
    output logic                    tmo_err
`endif
);
    sched_state_t       r_state;
    logic [DIM_W-1:0]   r_pic_w, r_pic_h, r_slice_w, r_slice_h;
    logic [DIM_W-1:0]   r_x, r_y;
    logic [2*DIM_W-1:0] r_cnt;
    logic               r_cfg_err;

    logic [DIM_W-1:0]   w_rem_w, w_rem_h, w_slc_w, w_slc_h;
    logic [DIM_W:0]     w_x_end, w_y_end;
    logic               w_row_end, w_last, w_hs, w_tmo;

    assign w_rem_w   = r_pic_w - r_x;
    assign w_rem_h   = r_pic_h - r_y;
    assign w_slc_w   = (r_slice_w < w_rem_w) ? r_slice_w : w_rem_w;
    assign w_slc_h   = (r_slice_h < w_rem_h) ? r_slice_h : w_rem_h;
    // One extra bit keeps origin+size from wrapping near the top of the range.
    assign w_x_end   = {1'b0, r_x} + {1'b0, w_slc_w};
    assign w_y_end   = {1'b0, r_y} + {1'b0, w_slc_h};
    assign w_row_end = (w_x_end >= {1'b0, r_pic_w});
    assign w_last    = w_row_end && (w_y_end >= {1'b0, r_pic_h});
    assign w_hs      = (r_state == S_ISSUE) && slc.slc_rdy;

`ifdef DSC_SLICE_TMO_EN
    logic w_wdog_hit;

    dsc_slice_wdog #(.TMO_W(TMO_W)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_hs),
        .i_run   (r_state == S_WAIT),
        .i_limit (tmo_limit),
        .o_hit   (w_wdog_hit)
    );

    // A completion arriving in the expiry cycle wins over the timeout.
    assign tmo_err = w_wdog_hit && !slc.slc_done;
    assign w_tmo   = tmo_err;
`else
    assign w_tmo   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pic_w   <= '0;
            r_pic_h   <= '0;
            r_slice_w <= '0;
            r_slice_h <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pic_w   <= pic_w;
                        r_pic_h   <= pic_h;
                        r_slice_w <= slice_w;
                        r_slice_h <= slice_h;
                        r_x       <= '0;
                        r_y       <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((r_pic_w == '0) || (r_pic_h == '0) ||
                        (r_slice_w == '0) || (r_slice_h == '0)) begin
                        r_cfg_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_hs) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (slc.slc_done) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            if (w_row_end) begin
                                r_x <= '0;
                                r_y <= r_y + r_slice_h;
                            end else begin
                                r_x <= r_x + r_slice_w;
                            end
                            r_state <= S_ISSUE;
                        end
                    end else if (w_tmo) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign slc.slc_vld  = (r_state == S_ISSUE);
    assign slc.slc_x    = r_x;
    assign slc.slc_y    = r_y;
    assign slc.slc_w    = w_slc_w;
    assign slc.slc_h    = w_slc_h;
    // Geometry looks "last" when idle with zeroed dims, so qualify by state.
    assign slc.slc_last = w_last && ((r_state == S_ISSUE) || (r_state == S_WAIT));
    assign busy         = (r_state != S_IDLE);
    assign frame_done   = (r_state == S_DONE);
    assign cfg_err      = r_cfg_err;
    assign slc_cnt      = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_dsc_slice_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsc_slice_sched
// Brief    : Scoreboard bench for dsc_slice_sched (DSC_SLICE_TMO_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsc_slice_sched;
    import dsc_pkg::*;

    localparam int DW = DSC_DIM_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [DW-1:0]   pic_w, pic_h, slice_w, slice_h;
    logic            busy, frame_done, cfg_err;
    logic [2*DW-1:0] slc_cnt;
`ifdef DSC_SLICE_TMO_EN
    logic [DSC_TMO_W-1:0] tmo_limit;
    logic                 tmo_err;
`endif

    dsc_slice_sched_if #(.DIM_W(DW)) slc_if ();

    dsc_slice_sched #(.DIM_W(DW), .TMO_W(DSC_TMO_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pic_w      (pic_w),
        .pic_h      (pic_h),
        .slice_w    (slice_w),
        .slice_h    (slice_h),
        .slc        (slc_if),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err),
        .slc_cnt    (slc_cnt)
`ifdef DSC_SLICE_TMO_EN
        ,
        .tmo_limit  (tmo_limit),
        .tmo_err    (tmo_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; int w; int h; bit last;
    } cmd_t;

    cmd_t exp_cmd[$];
    int   exp_end[$];        // >=0 frame_done with slice count, -1 cfg_err, -2 tmo_err
    int   n_pass = 0, n_total = 0;
    int   hs_count = 0, ends_seen = 0, fd_count = 0;
    bit   rdy_rand = 0, rdy_force = 1, resp_en = 1, stray_done = 0;
    int   done_dly = 5;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: raster walk of the picture in plain integer arithmetic.
    function automatic void push_model(input dsc_cfg_t c);
        int pw = c.pic_w, ph = c.pic_h, sw = c.slice_w, sh = c.slice_h, n = 0;
        if (pw == 0 || ph == 0 || sw == 0 || sh == 0) begin
            exp_end.push_back(-1);
            return;
        end
        for (int y = 0; y < ph; y += sh) begin
            for (int x = 0; x < pw; x += sw) begin
                cmd_t e;
                e.x = x; e.y = y;
                e.w = (pw - x < sw) ? pw - x : sw;
                e.h = (ph - y < sh) ? ph - y : sh;
                e.last = (x + e.w >= pw) && (y + e.h >= ph);
                exp_cmd.push_back(e);
                n++;
            end
        end
        exp_end.push_back(n);
    endfunction

    task automatic end_evt(input string nm, input int got);
        int e = (exp_end.size() != 0) ? exp_end.pop_front() : -99;
        ends_seen++;
        chk(nm, got, e);
    endtask

    // Monitor / scoreboard
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (slc_if.slc_vld && slc_if.slc_rdy) begin
                    hs_count++;
                    n_total++;
                    if (exp_cmd.size() == 0) begin
                        $display("FAIL slice: unexpected command (%0d,%0d) %0dx%0d",
                                 slc_if.slc_x, slc_if.slc_y, slc_if.slc_w, slc_if.slc_h);
                    end else begin
                        e = exp_cmd.pop_front();
                        if (slc_if.slc_x == e.x && slc_if.slc_y == e.y && slc_if.slc_w == e.w &&
                            slc_if.slc_h == e.h && slc_if.slc_last == e.last)
                            n_pass++;
                        else
                            $display("FAIL slice: got (%0d,%0d) %0dx%0d last=%0d expected (%0d,%0d) %0dx%0d last=%0d",
                                     slc_if.slc_x, slc_if.slc_y, slc_if.slc_w, slc_if.slc_h,
                                     slc_if.slc_last, e.x, e.y, e.w, e.h, e.last);
                    end
                end
                if (frame_done) begin
                    fd_count++;
                    end_evt("frame_done_cnt", int'(slc_cnt));
                end
                if (cfg_err) end_evt("cfg_err", -1);
`ifdef DSC_SLICE_TMO_EN
                if (tmo_err) end_evt("tmo_err", -2);
`endif
            end
        end
    end

    // Core model: ready pattern and delayed completion pulse
    initial begin
        int pend = 0, seen = 0;
        slc_if.slc_rdy  = 1'b0;
        slc_if.slc_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            slc_if.slc_done = stray_done;
            if (!rst_n) begin
                pend = 0; seen = hs_count;
            end else if (hs_count != seen) begin
                seen = hs_count; pend = done_dly;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0 && resp_en) slc_if.slc_done = 1'b1;
            end
            slc_if.slc_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    task automatic start_frame(input int pw, ph, sw, sh, input bit model);
        dsc_cfg_t c;
        c.pic_w = DW'(pw); c.pic_h = DW'(ph); c.slice_w = DW'(sw); c.slice_h = DW'(sh);
        if (model) push_model(c);
        @(posedge clk); #1;
        pic_w = c.pic_w; pic_h = c.pic_h; slice_w = c.slice_w; slice_h = c.slice_h;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int n0);
        int k = 0;
        while (ends_seen == n0 && k < 20000) begin
            @(posedge clk); k++;
        end
        chk("frame_end_seen", ends_seen != n0, 1);
    endtask

    task automatic run_frame(input int pw, ph, sw, sh);
        int n0 = ends_seen;
        start_frame(pw, ph, sw, sh, 1'b1);
        wait_end(n0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_flags"}, {busy, slc_if.slc_vld, slc_if.slc_last, frame_done, cfg_err}, 0);
        chk({nm, "_geom"}, {slc_if.slc_x, slc_if.slc_y, slc_if.slc_w, slc_if.slc_h}, 0);
        chk({nm, "_cnt"}, slc_cnt, 0);
    endtask

    initial begin
        int n0, fd0, k, hs, pw, ph, sw, sh;
        rst_n = 1'b0; start = 1'b0;
        pic_w = '0; pic_h = '0; slice_w = '0; slice_h = '0;
`ifdef DSC_SLICE_TMO_EN
        tmo_limit = '0;
`endif
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // 64x32 picture, 32x16 slices, immediate ready
        fd0 = fd_count;
        run_frame(64, 32, 32, 16);
        chk("frame_done_once", fd_count - fd0, 1);
        chk("cnt_64x32", slc_cnt, 4);
        repeat (3) @(negedge clk);
        chk("cnt_held", slc_cnt, 4);
        chk("idle_busy", busy, 0);

        // Truncated edge slices
        run_frame(70, 20, 32, 16);
        chk("cnt_70x20", slc_cnt, 6);

        // Zero dimension: cfg_err two cycles after start
        n0 = ends_seen;
        start_frame(64, 32, 0, 16, 1'b1);
        @(negedge clk);
        chk("cfg_err_early", cfg_err, 0);
        chk("check_busy", busy, 1);
        @(negedge clk);
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_busy", busy, 0);
        @(negedge clk);
        chk("cfg_err_clear", cfg_err, 0);
        wait_end(n0);

        // Back-pressure with stray done/start in ISSUE
        rdy_force = 1'b0;
        n0 = ends_seen;
        start_frame(64, 32, 32, 16, 1'b1);
        k = 0;
        while (!slc_if.slc_vld && k < 50) begin @(negedge clk); k++; end
        chk("vld_seen", slc_if.slc_vld, 1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_payload", {slc_if.slc_x, slc_if.slc_y, slc_if.slc_w, slc_if.slc_h},
                {16'd0, 16'd0, 16'd32, 16'd16});
            if (i == 2) stray_done = 1'b1;
            if (i == 3) stray_done = 1'b0;
            if (i == 4) begin pic_w = 16; pic_h = 16; start = 1'b1; end
            if (i == 5) start = 1'b0;
            @(negedge clk);
        end
        chk("vld_still", slc_if.slc_vld, 1);
        rdy_force = 1'b1;
        wait_end(n0);
        chk("cnt_after_stray", slc_cnt, 4);

        // Reset while the second slice is outstanding
        fd0 = fd_count;
        start_frame(64, 32, 32, 16, 1'b1);
        hs = 0; k = 0;
        while (hs < 2 && k < 200) begin
            @(negedge clk);
            if (slc_if.slc_vld && slc_if.slc_rdy) hs++;
            k++;
        end
        chk("second_hs", hs, 2);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        exp_cmd.delete();
        exp_end.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk("no_fd_on_rst", fd_count - fd0, 0);
        run_frame(64, 32, 32, 16);
        chk("cnt_after_rst", slc_cnt, 4);

        // Boundary shapes
        run_frame(10, 7, 32, 16);
        chk("cnt_single", slc_cnt, 1);
        run_frame(3, 2, 1, 1);
        chk("cnt_1x1", slc_cnt, 6);
        run_frame(65535, 1, 40000, 65535);
        chk("cnt_max", slc_cnt, 2);

        // Randomized frames with random ready and completion latency
        rdy_rand = 1'b1;
        for (int i = 0; i < 6; i++) begin
            done_dly = $urandom_range(1, 6);
            pw = $urandom_range(1, 90); ph = $urandom_range(1, 60);
            sw = $urandom_range(4, 40); sh = $urandom_range(4, 30);
            run_frame(pw, ph, sw, sh);
            chk("rand_cnt", slc_cnt, ((pw + sw - 1) / sw) * ((ph + sh - 1) / sh));
        end
        rdy_rand = 1'b0; rdy_force = 1'b1; done_dly = 5;

`ifdef DSC_SLICE_TMO_EN
        // Watchdog: no completion for the first slice
        tmo_limit = 20'd8;
        resp_en = 1'b0;
        fd0 = fd_count;
        n0 = ends_seen;
        exp_cmd.push_back('{0, 0, 32, 16, 1'b0});
        exp_end.push_back(-2);
        start_frame(64, 32, 32, 16, 1'b0);
        k = 0;
        while (!(slc_if.slc_vld && slc_if.slc_rdy) && k < 50) begin @(negedge clk); k++; end
        k = 0;
        while (!tmo_err && k < 100) begin @(negedge clk); k++; end
        chk("tmo_cycles", k, 8);
        wait_end(n0);
        @(negedge clk);
        chk("tmo_idle", busy, 0);
        chk("tmo_no_fd", fd_count - fd0, 0);
        resp_en = 1'b1;
        tmo_limit = '0;
        run_frame(64, 32, 32, 16);
        chk("cnt_after_tmo", slc_cnt, 4);
`endif

        repeat (5) @(negedge clk);
        chk("cmd_q_empty", exp_cmd.size(), 0);
        chk("end_q_empty", exp_end.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
